// File: rtl/ddc_sched_pkg.sv
// Shared types and defaults for the DDC phase-load scheduler.
// Holds the channel record, the FSM state encoding and the default sizing.
package ddc_sched_pkg;

    localparam int NCH         = 8;
    localparam int DDS_LATENCY = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SNAP   = 2'd1,
        ST_LOAD   = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    typedef struct packed {
        logic        en;
        logic [31:0] poff;
        logic [31:0] pinc;
    } ch_cfg_t;

endpackage

// File: rtl/phase_bank.sv
// Double-buffered per-channel phase configuration: software writes the shadow
// bank at any time, a snapshot strobe copies it whole into the active bank.
module phase_bank
    import ddc_sched_pkg::*;
#(
    parameter int N = ddc_sched_pkg::NCH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [$clog2(N)-1:0] wr_addr,
    input  ch_cfg_t              wr_data,
    input  logic                 snap,
    input  logic [$clog2(N)-1:0] rd_idx,
    output ch_cfg_t              rd_data,
    output logic [N-1:0]         shadow_en,
    output logic [N-1:0]         active_en
);

    ch_cfg_t [N-1:0] shadow_q;
    ch_cfg_t [N-1:0] shadow_d;
    ch_cfg_t [N-1:0] active_q;
    ch_cfg_t [N-1:0] active_d;

    // The snapshot copies the pre-edge shadow, so a write on the snapshot
    // edge itself waits for the next sequence.
    always_comb begin
        shadow_d = shadow_q;
        if (wr_en) begin
            shadow_d[wr_addr] = wr_data;
        end
        active_d = snap ? shadow_q : active_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign rd_data = active_q[rd_idx];

    always_comb begin
        shadow_en = '0;
        active_en = '0;
        for (int i = 0; i < N; i++) begin
            shadow_en[i] = shadow_q[i].en;
            active_en[i] = active_q[i].en;
        end
    end

endmodule

// File: rtl/ddc_phase_sched.sv
// Commits a bank of per-channel DDS phase settings: snapshot, one load slot per
// channel, then wait out the DDS latency before flagging the DDC outputs valid.
module ddc_phase_sched
    import ddc_sched_pkg::*;
#(
    parameter int NCH         = ddc_sched_pkg::NCH,
    parameter int DDS_LATENCY = ddc_sched_pkg::DDS_LATENCY
) (
    input  logic            s_axis_aclk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [2:0]      cfg_addr,
    input  logic [31:0]     cfg_pinc,
    input  logic [31:0]     cfg_poff,
    input  logic            cfg_en,
    input  logic            commit,
    input  logic            commit_resync,
    output logic [63:0]     m_axis_phase_tdata,
    output logic [NCH-1:0]  m_axis_phase_tvalid,
    output logic [NCH-1:0]  resync,
    output logic [NCH-1:0]  ddc_en,
    output logic            busy,
    output logic            done
);

    localparam int IW = $clog2(NCH);
    localparam int CW = (DDS_LATENCY > 1) ? $clog2(DDS_LATENCY) : 1;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           pending_q, pending_d;
    logic           pending_rs_q, pending_rs_d;
    logic           rs_flag_q, rs_flag_d;
    logic           fin_q, fin_d;
    logic           done_q, done_d;
    logic [NCH-1:0] tvalid_q, tvalid_d;
    logic [NCH-1:0] resync_q, resync_d;
    logic [NCH-1:0] ddc_en_q, ddc_en_d;
    logic [63:0]    tdata_q, tdata_d;

    logic           snap;
    ch_cfg_t        wr_data;
    ch_cfg_t        rd_data;
    logic [NCH-1:0] shadow_en;
    logic [NCH-1:0] active_en;

    assign wr_data = '{en: cfg_en, poff: cfg_poff, pinc: cfg_pinc};

    phase_bank #(.N(NCH)) u_bank (
        .clk       (s_axis_aclk),
        .rst       (rst),
        .wr_en     (cfg_we),
        .wr_addr   (cfg_addr[IW-1:0]),
        .wr_data   (wr_data),
        .snap      (snap),
        .rd_idx    (idx_q),
        .rd_data   (rd_data),
        .shadow_en (shadow_en),
        .active_en (active_en)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q;
        pending_rs_d = pending_rs_q;
        rs_flag_d    = rs_flag_q;
        fin_d        = 1'b0;
        snap         = 1'b0;
        tvalid_d     = '0;
        resync_d     = '0;
        tdata_d      = tdata_q;
        ddc_en_d     = ddc_en_q;
        // done and the new enable mask land one cycle after the FSM is idle again.
        done_d       = fin_q;
        if (fin_q) begin
            ddc_en_d = active_en;
        end

        case (state_q)
            ST_IDLE: begin
                if (commit || pending_q) begin
                    state_d = ST_SNAP;
                    if (commit) begin
                        pending_rs_d = pending_rs_q | commit_resync;
                    end
                end
            end
            ST_SNAP: begin
                snap         = 1'b1;
                rs_flag_d    = pending_rs_q;
                ddc_en_d     = '0;
                pending_d    = commit;
                pending_rs_d = commit & commit_resync;
                idx_d        = '0;
                // Shadow is what active becomes on this edge, so test it directly.
                if (shadow_en == '0) begin
                    state_d = ST_IDLE;
                    fin_d   = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (rd_data.en) begin
                    tvalid_d[idx_q] = 1'b1;
                    resync_d[idx_q] = rs_flag_q;
                    tdata_d         = {rd_data.poff, rd_data.pinc};
                end
                if (idx_q == IW'(NCH - 1)) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CW'(DDS_LATENCY - 1);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    fin_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Commits arriving mid-sequence fold into a single queued request.
        if ((state_q == ST_LOAD || state_q == ST_SETTLE) && commit) begin
            pending_d    = 1'b1;
            pending_rs_d = pending_rs_q | commit_resync;
        end
    end

    always_ff @(posedge s_axis_aclk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            pending_rs_q <= 1'b0;
            rs_flag_q    <= 1'b0;
            fin_q        <= 1'b0;
            done_q       <= 1'b0;
            tvalid_q     <= '0;
            resync_q     <= '0;
            ddc_en_q     <= '0;
            tdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            pending_rs_q <= pending_rs_d;
            rs_flag_q    <= rs_flag_d;
            fin_q        <= fin_d;
            done_q       <= done_d;
            tvalid_q     <= tvalid_d;
            resync_q     <= resync_d;
            ddc_en_q     <= ddc_en_d;
            tdata_q      <= tdata_d;
        end
    end

    assign m_axis_phase_tdata  = tdata_q;
    assign m_axis_phase_tvalid = tvalid_q;
    assign resync              = resync_q;
    assign ddc_en              = ddc_en_q;
    assign busy                = (state_q != ST_IDLE);
    assign done                = done_q;

endmodule

// File: tb/tb_ddc_phase_sched.sv
// Directed plus randomized bench for ddc_phase_sched against a timeline model:
// each accepted commit schedules its per-cycle output events from the timing rules.
module tb_ddc_phase_sched;

    localparam int MAXC = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [31:0] cfg_pinc = '0;
    logic [31:0] cfg_poff = '0;
    logic        cfg_en = 1'b0;
    logic        commit = 1'b0;
    logic        commit_resync = 1'b0;
    logic [63:0] tdata;
    logic [7:0]  tvalid;
    logic [7:0]  resync;
    logic [7:0]  ddc_en;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    ddc_phase_sched dut (
        .s_axis_aclk         (clk),
        .rst                 (rst),
        .cfg_we              (cfg_we),
        .cfg_addr            (cfg_addr),
        .cfg_pinc            (cfg_pinc),
        .cfg_poff            (cfg_poff),
        .cfg_en              (cfg_en),
        .commit              (commit),
        .commit_resync       (commit_resync),
        .m_axis_phase_tdata  (tdata),
        .m_axis_phase_tvalid (tvalid),
        .resync              (resync),
        .ddc_en              (ddc_en),
        .busy                (busy),
        .done                (done)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: shadow copy plus an event timeline indexed by edge number.
    bit          m_en[8];
    bit [31:0]   m_pinc[8];
    bit [31:0]   m_poff[8];
    int          free_at;
    bit          pend;
    bit          pend_rs;
    bit [7:0]    e_tv[MAXC];
    bit [7:0]    e_rs[MAXC];
    bit [63:0]   e_td[MAXC];
    bit          e_done[MAXC];
    bit          e_busy[MAXC];
    bit          e_ddc_set[MAXC];
    bit [7:0]    e_ddc_val[MAXC];
    bit [7:0]    x_ddc;
    bit [63:0]   x_td;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = cyc; k < cyc + 40 && k < MAXC; k++) begin
            e_tv[k] = '0; e_rs[k] = '0; e_td[k] = '0; e_done[k] = 1'b0;
            e_busy[k] = 1'b0; e_ddc_set[k] = 1'b0; e_ddc_val[k] = '0;
        end
        for (int i = 0; i < 8; i++) begin
            m_en[i] = 1'b0; m_pinc[i] = '0; m_poff[i] = '0;
        end
        free_at = 0; pend = 1'b0; pend_rs = 1'b0; x_ddc = '0; x_td = '0;
    endtask

    // A sequence accepted at edge s: snapshot at s+1, channel i loads at s+2+i,
    // done and the enable mask appear at s+18 (s+2 when nothing is enabled).
    task automatic start_seq(input int s, input bit rs);
        bit [7:0] mask;
        mask = '0;
        for (int i = 0; i < 8; i++) mask[i] = m_en[i];
        e_ddc_set[s + 1] = 1'b1; e_ddc_val[s + 1] = '0;
        if (mask == '0) begin
            e_busy[s] = 1'b1;
            e_done[s + 2] = 1'b1;
            e_ddc_set[s + 2] = 1'b1; e_ddc_val[s + 2] = '0;
            free_at = s + 2;
        end else begin
            for (int k = s; k <= s + 16; k++) e_busy[k] = 1'b1;
            for (int i = 0; i < 8; i++) begin
                if (m_en[i]) begin
                    e_tv[s + 2 + i] = 8'(1 << i);
                    e_rs[s + 2 + i] = rs ? 8'(1 << i) : 8'h00;
                    e_td[s + 2 + i] = {m_poff[i], m_pinc[i]};
                end
            end
            e_done[s + 18] = 1'b1;
            e_ddc_set[s + 18] = 1'b1; e_ddc_val[s + 18] = mask;
            free_at = s + 18;
        end
    endtask

    task automatic model_edge();
        bit started;
        started = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            if (commit) begin
                if (cyc < free_at) begin
                    pend = 1'b1;
                    pend_rs = pend_rs | commit_resync;
                end else begin
                    started = 1'b1;
                end
            end
            if (cfg_we) begin
                m_en[cfg_addr] = cfg_en; m_pinc[cfg_addr] = cfg_pinc; m_poff[cfg_addr] = cfg_poff;
            end
            if (started) begin
                start_seq(cyc, commit_resync | pend_rs);
                pend = 1'b0; pend_rs = 1'b0;
            end else if (pend && cyc == free_at) begin
                start_seq(cyc, pend_rs);
                pend = 1'b0; pend_rs = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        if (e_ddc_set[cyc]) x_ddc = e_ddc_val[cyc];
        if (e_tv[cyc] != '0) x_td = e_td[cyc];
        chk("tvalid", 64'(tvalid), 64'(e_tv[cyc]));
        chk("resync", 64'(resync), 64'(e_rs[cyc]));
        chk("done", 64'(done), 64'(e_done[cyc]));
        chk("busy", 64'(busy), 64'(e_busy[cyc]));
        chk("ddc_en", 64'(ddc_en), 64'(x_ddc));
        chk("tdata", tdata, x_td);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        cfg_we = 1'b0; commit = 1'b0; commit_resync = 1'b0;
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input int a, input bit en, input bit [31:0] pinc, input bit [31:0] poff);
        cfg_we = 1'b1; cfg_addr = 3'(a); cfg_en = en; cfg_pinc = pinc; cfg_poff = poff;
        step();
    endtask

    task automatic do_commit(input bit rs);
        commit = 1'b1; commit_resync = rs;
        step();
    endtask

    initial begin
        model_reset();
        run(3);
        rst = 1'b0;
        run(2);

        // Single channel with resync.
        wr(0, 1'b1, 32'h0100_0000, 32'h0);
        do_commit(1'b1);
        run(2);
        chk("r40_tvalid", 64'(tvalid), 64'h01);
        chk("r40_tdata", tdata, 64'h0000_0000_0100_0000);
        chk("r40_resync", 64'(resync), 64'h01);
        run(16);
        chk("r40_done", 64'(done), 64'h1);
        chk("r40_ddc_en", 64'(ddc_en), 64'h01);
        run(3);

        // Channels 1, 3, 7.
        wr(0, 1'b0, 32'h0, 32'h0);
        wr(1, 1'b1, 32'h1111_0001, 32'h0000_00A0);
        wr(3, 1'b1, 32'h3333_0003, 32'h0000_00B0);
        wr(7, 1'b1, 32'h7777_0007, 32'h0000_00C0);
        do_commit(1'b0);
        run(3);
        chk("r41_t3", 64'(tvalid), 64'h02);
        chk("r41_d3", tdata, 64'h0000_00A0_1111_0001);
        run(2);
        chk("r41_t5", 64'(tvalid), 64'h08);
        run(4);
        chk("r41_t9", 64'(tvalid), 64'h80);
        chk("r41_d9", tdata, 64'h0000_00C0_7777_0007);
        run(9);
        chk("r41_ddc_en", 64'(ddc_en), 64'h8A);
        run(2);

        // Queued commit plus a mid-sequence write to ch1.
        do_commit(1'b1);
        run(4);
        do_commit(1'b0);
        wr(1, 1'b1, 32'hABCD_1234, 32'h5555_0000);
        run(15);
        chk("r42_t1_new", 64'(tvalid), 64'h02);
        chk("r42_d1_new", tdata, 64'h5555_0000_ABCD_1234);
        run(20);

        // Simultaneous write and commit in idle.
        cfg_we = 1'b1; cfg_addr = 3'd5; cfg_en = 1'b1;
        cfg_pinc = 32'h0505_0505; cfg_poff = 32'h5050_5050;
        commit = 1'b1; commit_resync = 1'b1;
        step();
        run(7);
        chk("r32_t5", 64'(tvalid), 64'h20);
        run(15);

        // Everything disabled.
        for (int i = 0; i < 8; i++) wr(i, 1'b0, 32'h0, 32'h0);
        do_commit(1'b0);
        run(2);
        chk("r43_done", 64'(done), 64'h1);
        chk("r43_ddc_en", 64'(ddc_en), 64'h0);
        run(3);

        // Reset in the middle of a load.
        wr(2, 1'b1, 32'h2222_2222, 32'h0);
        wr(6, 1'b1, 32'h6666_6666, 32'h0);
        do_commit(1'b1);
        run(5);
        rst = 1'b1;
        #1;
        chk("r44_tvalid", 64'(tvalid), 64'h0);
        chk("r44_busy", 64'(busy), 64'h0);
        chk("r44_tdata", tdata, 64'h0);
        chk("r44_ddc_en", 64'(ddc_en), 64'h0);
        model_reset();
        run(2);
        rst = 1'b0;
        run(25);
        wr(4, 1'b1, 32'h4444_0004, 32'h0000_0044);
        do_commit(1'b0);
        run(22);

        // Randomized traffic.
        repeat (800) begin
            cfg_we = ($urandom_range(0, 3) == 0);
            cfg_addr = 3'($urandom_range(0, 7));
            cfg_en = 1'($urandom_range(0, 1));
            cfg_pinc = $urandom;
            cfg_poff = $urandom;
            commit = ($urandom_range(0, 24) == 0);
            commit_resync = 1'($urandom_range(0, 1));
            step();
        end
        run(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
